// File: rtl/core_wb_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// core_wb_regfile_sb_pkg : shared widths and index constants for the regfile
// Revision: 1.0
// ============================================================================
package core_wb_regfile_sb_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_NREG = 32;
  localparam int CORE_AW   = $clog2(CORE_NREG);
  localparam int X0_IDX    = 0;

  typedef logic [CORE_AW-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/core_wb_regfile_sb_busy.sv
`default_nettype none
// ============================================================================
// core_sb_busy : per-register busy scoreboard, pending counter, RAW/WAW stall
// Revision: 1.0
// ============================================================================
module core_sb_busy
  import core_wb_regfile_sb_pkg::*;
#(
  parameter int NREG = CORE_NREG,
  parameter int AW   = CORE_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic          iss_valid_i,
  input  logic          iss_rd_wen_i,
  input  logic [AW-1:0] iss_rd_i,
  input  logic          iss_rs1_en_i,
  input  logic [AW-1:0] iss_rs1_i,
  input  logic          iss_rs2_en_i,
  input  logic [AW-1:0] iss_rs2_i,
  output logic          hazard_o,
  output logic [AW:0]   pending_cnt_o
);

  localparam logic [AW-1:0] X0 = AW'(X0_IDX);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_vec, clr_vec;
  logic [AW:0]     cnt_q, cnt_d;
  logic            raw1, raw2, waw;
  logic            fire, set_vld, clr_vld, inc, dec;

  // A writeback landing this cycle resolves the dependency through the bypass.
  assign raw1 = iss_rs1_en_i && (iss_rs1_i != X0) && busy_q[iss_rs1_i]
                && !(wb_en_i && (wb_rd_i == iss_rs1_i));
  assign raw2 = iss_rs2_en_i && (iss_rs2_i != X0) && busy_q[iss_rs2_i]
                && !(wb_en_i && (wb_rd_i == iss_rs2_i));
  assign waw  = iss_rd_wen_i && (iss_rd_i != X0) && busy_q[iss_rd_i]
                && !(wb_en_i && (wb_rd_i == iss_rd_i));

  assign hazard_o = iss_valid_i && (raw1 || raw2 || waw);
  assign fire     = iss_valid_i && !hazard_o;
  assign set_vld  = fire && iss_rd_wen_i && (iss_rd_i != X0);
  assign clr_vld  = wb_en_i && (wb_rd_i != X0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_vld) set_vec[iss_rd_i] = 1'b1;
    if (clr_vld) clr_vec[wb_rd_i] = 1'b1;
    // Set applied after clear: the newer producer owns the register.
    busy_d = (busy_q & ~clr_vec) | set_vec;
    inc    = set_vld && !busy_q[iss_rd_i];
    dec    = clr_vld && busy_q[wb_rd_i] && !(set_vld && (iss_rd_i == wb_rd_i));
    cnt_d  = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/core_wb_regfile_sb.sv
`default_nettype none
// ============================================================================
// core_wb_regfile_sb : integer register file with writeback bypass and scoreboard
// Revision: 1.0
// ============================================================================
module core_wb_regfile_sb
  import core_wb_regfile_sb_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int NREG = CORE_NREG,
  parameter int AW   = CORE_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            iss_valid_i,
  input  logic            iss_rd_wen_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic            iss_rs1_en_i,
  input  logic [AW-1:0]   iss_rs1_i,
  input  logic            iss_rs2_en_i,
  input  logic [AW-1:0]   iss_rs2_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            hazard_o,
  output logic [AW:0]     pending_cnt_o
);

  localparam logic [AW-1:0] X0 = AW'(X0_IDX);

  logic [XLEN-1:0] regs_q [NREG];

  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   idx,
    input logic            wen,
    input logic [AW-1:0]   wrd,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] stored
  );
    if (idx == X0)                  return '0;
    else if (wen && (wrd == idx))   return wdata;
    else                            return stored;
  endfunction

  // Entry 0 is reset and never written, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en_i && (wb_rd_i != X0)) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  assign rs1_data_o = read_port(iss_rs1_i, wb_en_i, wb_rd_i, wb_data_i, regs_q[iss_rs1_i]);
  assign rs2_data_o = read_port(iss_rs2_i, wb_en_i, wb_rd_i, wb_data_i, regs_q[iss_rs2_i]);

  core_sb_busy #(
    .NREG (NREG),
    .AW   (AW)
  ) u_busy (
    .clk           (clk),
    .rst           (rst),
    .wb_en_i       (wb_en_i),
    .wb_rd_i       (wb_rd_i),
    .iss_valid_i   (iss_valid_i),
    .iss_rd_wen_i  (iss_rd_wen_i),
    .iss_rd_i      (iss_rd_i),
    .iss_rs1_en_i  (iss_rs1_en_i),
    .iss_rs1_i     (iss_rs1_i),
    .iss_rs2_en_i  (iss_rs2_en_i),
    .iss_rs2_i     (iss_rs2_i),
    .hazard_o      (hazard_o),
    .pending_cnt_o (pending_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_core_wb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_core_wb_regfile_sb : directed + randomized bench with behavioural model
// Revision: 1.0
// ============================================================================
module tb_core_wb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        iss_valid = 1'b0;
  logic        iss_rd_wen = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_rs1_en = 1'b0;
  logic [4:0]  iss_rs1 = '0;
  logic        iss_rs2_en = 1'b0;
  logic [4:0]  iss_rs2 = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        hazard;
  logic [5:0]  pending_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  // Reference state: architectural values and outstanding-producer flags.
  logic [31:0] m_regs [32];
  bit   [31:0] m_busy;

  always #5 clk = ~clk;

  core_wb_regfile_sb dut (
    .clk           (clk),
    .rst           (rst),
    .wb_en_i       (wb_en),
    .wb_rd_i       (wb_rd),
    .wb_data_i     (wb_data),
    .iss_valid_i   (iss_valid),
    .iss_rd_wen_i  (iss_rd_wen),
    .iss_rd_i      (iss_rd),
    .iss_rs1_en_i  (iss_rs1_en),
    .iss_rs1_i     (iss_rs1),
    .iss_rs2_en_i  (iss_rs2_en),
    .iss_rs2_i     (iss_rs2),
    .rs1_data_o    (rs1_data),
    .rs2_data_o    (rs2_data),
    .hazard_o      (hazard),
    .pending_cnt_o (pending_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_waiting(input bit en, input logic [4:0] idx);
    return en && idx != 0 && m_busy[idx] && !(wb_en && wb_rd == idx);
  endfunction

  function automatic bit m_hazard();
    return iss_valid && (m_waiting(iss_rs1_en, iss_rs1) || m_waiting(iss_rs2_en, iss_rs2)
                         || m_waiting(iss_rd_wen, iss_rd));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_busy = '0;
    end else begin
      bit fire;
      fire = iss_valid && !m_hazard();
      if (wb_en && wb_rd != 0) begin
        m_regs[wb_rd] = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (fire && iss_rd_wen && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("cmp_rs1", rs1_data, m_read(iss_rs1));
      chk("cmp_rs2", rs2_data, m_read(iss_rs2));
      chk("cmp_hazard", {31'd0, hazard}, {31'd0, m_hazard()});
      chk("cmp_pending", {26'd0, pending_cnt}, 32'($countones(m_busy)));
    end
  end

  task automatic idle();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    iss_valid = 0; iss_rd_wen = 0; iss_rd = 0;
    iss_rs1_en = 0; iss_rs1 = 0; iss_rs2_en = 0; iss_rs2 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_idx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run = 1;

    // Reset state across every index.
    for (int r = 1; r < 32; r++) begin
      cyc(); idle(); iss_rs1 = 5'(r); iss_rs2 = 5'(r); #1;
      chk("rst_rs1", rs1_data, 32'd0);
      chk("rst_hazard", {31'd0, hazard}, 32'd0);
      chk("rst_pending", {26'd0, pending_cnt}, 32'd0);
    end

    // Write, same-cycle bypass, then storage.
    cyc(); idle(); wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; iss_rs1 = 5; #1;
    chk("bypass_rs1", rs1_data, 32'hDEADBEEF);
    cyc(); idle(); iss_rs1 = 5; #1;
    chk("stored_rs1", rs1_data, 32'hDEADBEEF);

    // x0 protection.
    cyc(); idle(); wb_en = 1; wb_rd = 0; wb_data = 32'h1234; iss_rs1 = 0; #1;
    chk("x0_bypass", rs1_data, 32'd0);
    cyc(); idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd = 0; #1;
    cyc(); idle(); #1;
    chk("x0_pending", {26'd0, pending_cnt}, 32'd0);
    chk("x0_read", rs1_data, 32'd0);

    // RAW stall on x7 until its writeback arrives.
    cyc(); idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd = 7; #1;
    chk("raw_issue_hazard", {31'd0, hazard}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); iss_valid = 1; iss_rs2_en = 1; iss_rs2 = 7; #1;
      chk("raw_stall", {31'd0, hazard}, 32'd1);
      chk("raw_pending1", {26'd0, pending_cnt}, 32'd1);
    end
    cyc(); idle(); iss_valid = 1; iss_rs2_en = 1; iss_rs2 = 7;
    wb_en = 1; wb_rd = 7; wb_data = 32'h55; #1;
    chk("raw_resolved", {31'd0, hazard}, 32'd0);
    chk("raw_bypass", rs2_data, 32'h55);
    chk("raw_pending_pre", {26'd0, pending_cnt}, 32'd1);
    cyc(); idle(); #1;
    chk("raw_pending_post", {26'd0, pending_cnt}, 32'd0);

    // WAW with same-cycle writeback: set wins.
    cyc(); idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd = 9; #1;
    cyc(); idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd = 9;
    wb_en = 1; wb_rd = 9; wb_data = 32'hA5A5A5A5; #1;
    chk("waw_hazard", {31'd0, hazard}, 32'd0);
    chk("waw_pending_pre", {26'd0, pending_cnt}, 32'd1);
    cyc(); idle(); iss_valid = 1; iss_rs1_en = 1; iss_rs1 = 9; #1;
    chk("waw_pending_post", {26'd0, pending_cnt}, 32'd1);
    chk("waw_data", rs1_data, 32'hA5A5A5A5);
    chk("waw_still_busy", {31'd0, hazard}, 32'd1);
    cyc(); idle(); wb_en = 1; wb_rd = 9; wb_data = 32'h9; #1;
    cyc(); idle(); wb_en = 1; wb_rd = 12; wb_data = 32'hC0FFEE; #1;
    chk("spurious_pending", {26'd0, pending_cnt}, 32'd0);
    cyc(); idle(); iss_rs2 = 12; #1;
    chk("spurious_data", rs2_data, 32'hC0FFEE);

    // Asynchronous reset between edges.
    cyc(); idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd = 3; #1;
    cyc(); idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd = 4; #1;
    cyc(); idle(); iss_valid = 1; iss_rs1_en = 1; iss_rs1 = 3; iss_rs2 = 5; #1;
    chk("arst_pending_pre", {26'd0, pending_cnt}, 32'd2);
    chk("arst_hazard_pre", {31'd0, hazard}, 32'd1);
    rst = 1; #1;
    chk("arst_pending", {26'd0, pending_cnt}, 32'd0);
    chk("arst_hazard", {31'd0, hazard}, 32'd0);
    chk("arst_regs", rs2_data, 32'd0);
    cyc(); rst = 0; idle();

    // Randomized traffic, including rare asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      cyc();
      rst        = ($urandom_range(0, 199) == 0);
      iss_valid  = ($urandom_range(0, 3) != 0);
      iss_rd_wen = 1'($urandom_range(0, 1));
      iss_rd     = pick_idx();
      iss_rs1_en = 1'($urandom_range(0, 1));
      iss_rs1    = pick_idx();
      iss_rs2_en = 1'($urandom_range(0, 1));
      iss_rs2    = pick_idx();
      wb_en      = ($urandom_range(0, 2) == 0);
      wb_rd      = pick_idx();
      wb_data    = $urandom;
    end
    cyc(); rst = 0; idle();
    cyc();
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
